// File: rtl/ovf_event_logger.sv
// rtl/ovf_event_logger.sv - captures {q, timestamp} on overflow rising edges into a FIFO
// Status side keeps saturating event/drop counters and a sticky overflow flag.
module ovf_event_logger #(
    parameter int DATA_W = 8,
    parameter int TS_W   = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [DATA_W-1:0]          i_q_in,
    input  logic                       i_ovf_in,
    input  logic                       i_clear,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [DATA_W+TS_W-1:0]     o_rd_data,
    output logic                       o_fifo_full,
    output logic [$clog2(DEPTH):0]     o_fifo_level,
    output logic [CNT_W-1:0]           o_event_count,
    output logic [CNT_W-1:0]           o_drop_count,
    output logic                       o_ovf_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W+TS_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic [TS_W-1:0]        r_ts;
    logic                   r_ovf_prev;
    logic [CNT_W-1:0]       r_event_count;
    logic [CNT_W-1:0]       r_drop_count;
    logic                   r_ovf_seen;

    logic w_event;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_event = i_ovf_in & ~r_ovf_prev;
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = o_rd_valid & i_rd_ready;
    // A full FIFO still accepts the event when the head leaves on the same edge.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & ~w_push;

    assign o_rd_valid    = (r_level != '0);
    assign o_rd_data     = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_fifo_full   = w_full;
    assign o_fifo_level  = r_level;
    assign o_event_count = r_event_count;
    assign o_drop_count  = r_drop_count;
    assign o_ovf_seen    = r_ovf_seen;

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= {i_q_in, r_ts};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_ts          <= '0;
            r_ovf_prev    <= 1'b0;
            r_event_count <= '0;
            r_drop_count  <= '0;
            r_ovf_seen    <= 1'b0;
        end else begin
            r_ts       <= r_ts + TS_W'(1);
            r_ovf_prev <= i_ovf_in;
            if (i_clear) begin
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_level       <= '0;
                r_event_count <= '0;
                r_drop_count  <= '0;
                r_ovf_seen    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
                if (w_event) begin
                    r_ovf_seen <= 1'b1;
                    if (r_event_count != '1) begin
                        r_event_count <= r_event_count + CNT_W'(1);
                    end
                end
                if (w_drop && (r_drop_count != '1)) begin
                    r_drop_count <= r_drop_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ovf_event_logger.sv
// tb/tb_ovf_event_logger.sv - directed testbench for ovf_event_logger
module tb_ovf_event_logger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  q;
    logic        ovf;
    logic        clear;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        fifo_full;
    logic [2:0]  fifo_level;
    logic [7:0]  event_count;
    logic [7:0]  drop_count;
    logic        ovf_seen;

    logic [7:0]  cyc;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    ovf_event_logger #(.DATA_W(8), .TS_W(8), .DEPTH(4), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_q_in       (q),
        .i_ovf_in     (ovf),
        .i_clear      (clear),
        .o_rd_valid   (rd_valid),
        .i_rd_ready   (rd_ready),
        .o_rd_data    (rd_data),
        .o_fifo_full  (fifo_full),
        .o_fifo_level (fifo_level),
        .o_event_count(event_count),
        .o_drop_count (drop_count),
        .o_ovf_seen   (ovf_seen)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 8'd1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; q = '0; ovf = 1'b0; clear = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({rd_valid, fifo_full, fifo_level, event_count, drop_count, ovf_seen, rd_data} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {rd_valid, fifo_full, fifo_level, event_count, drop_count, ovf_seen, rd_data});
        end
        rst_n = 1'b1;
        cyc   = 8'd0;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({rd_valid, fifo_level, event_count, ovf_seen} !== 13'd0) begin
                miscompares++;
                $display("FAIL idle_%0d got valid=%b lvl=%0d ev=%0d seen=%b exp all 0",
                         i, rd_valid, fifo_level, event_count, ovf_seen);
            end
        end
    endtask

    task automatic test_capture;
        q = 8'h7F; ovf = 1'b1;
        tick();
        vectors++;
        if (rd_valid !== 1'b1) begin
            miscompares++; $display("FAIL cap_valid got=%b exp=1", rd_valid);
        end
        vectors++;
        if (rd_data !== 16'h7F05) begin
            miscompares++; $display("FAIL cap_data got=%h exp=7f05", rd_data);
        end
        vectors++;
        if (event_count !== 8'd1 || ovf_seen !== 1'b1 || fifo_level !== 3'd1) begin
            miscompares++;
            $display("FAIL cap_status got ev=%0d seen=%b lvl=%0d exp ev=1 seen=1 lvl=1",
                     event_count, ovf_seen, fifo_level);
        end
        repeat (4) tick();
        vectors++;
        if (event_count !== 8'd1 || rd_data !== 16'h7F05) begin
            miscompares++;
            $display("FAIL held_high got ev=%0d data=%h exp ev=1 data=7f05", event_count, rd_data);
        end
        ovf = 1'b0;
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            miscompares++;
            $display("FAIL cap_drain got valid=%b lvl=%0d exp 0 0", rd_valid, fifo_level);
        end
    endtask

    task automatic test_fill_drop;
        logic [7:0] ts_exp [5];
        logic [7:0] qv;
        for (int i = 0; i < 5; i++) begin
            qv = 8'(i + 1);
            q = qv; ovf = 1'b1; ts_exp[i] = cyc;
            tick();
            ovf = 1'b0;
            tick();
        end
        vectors++;
        if (fifo_full !== 1'b1 || fifo_level !== 3'd4 || drop_count !== 8'd1 || event_count !== 8'd6) begin
            miscompares++;
            $display("FAIL fill_status got full=%b lvl=%0d drop=%0d ev=%0d exp 1 4 1 6",
                     fifo_full, fifo_level, drop_count, event_count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qv = 8'(i + 1);
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== {qv, ts_exp[i]}) begin
                miscompares++;
                $display("FAIL drain_%0d got valid=%b data=%h exp 1 %h", i, rd_valid, rd_data, {qv, ts_exp[i]});
            end
            tick();
        end
        vectors++;
        if (rd_valid !== 1'b0 || fifo_full !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty got valid=%b full=%b exp 0 0", rd_valid, fifo_full);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        logic [7:0] ts_exp [4];
        logic [7:0] ts_aa;
        logic [7:0] qv;
        for (int i = 0; i < 4; i++) begin
            q = 8'h10 + 8'(i); ovf = 1'b1; ts_exp[i] = cyc;
            tick();
            ovf = 1'b0;
            tick();
        end
        vectors++;
        if (fifo_full !== 1'b1) begin
            miscompares++; $display("FAIL pp_full got=%b exp=1", fifo_full);
        end
        q = 8'hAA; ovf = 1'b1; rd_ready = 1'b1; ts_aa = cyc;
        tick();
        ovf = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4 || drop_count !== 8'd1 || event_count !== 8'd11) begin
            miscompares++;
            $display("FAIL pp_status got lvl=%0d drop=%0d ev=%0d exp 4 1 11",
                     fifo_level, drop_count, event_count);
        end
        for (int i = 1; i < 4; i++) begin
            qv = 8'h10 + 8'(i);
            vectors++;
            if (rd_data !== {qv, ts_exp[i]}) begin
                miscompares++;
                $display("FAIL pp_head_%0d got=%h exp=%h", i, rd_data, {qv, ts_exp[i]});
            end
            tick();
        end
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== {8'hAA, ts_aa}) begin
            miscompares++;
            $display("FAIL pp_tail got valid=%b data=%h exp 1 %h", rd_valid, rd_data, {8'hAA, ts_aa});
        end
        tick();
        rd_ready = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++; $display("FAIL pp_empty got=%b exp=0", rd_valid);
        end
    endtask

    task automatic test_clear;
        logic [7:0] t;
        for (int i = 0; i < 2; i++) begin
            q = 8'h21 + 8'(i); ovf = 1'b1;
            tick();
            ovf = 1'b0;
            tick();
        end
        vectors++;
        if (fifo_level !== 3'd2) begin
            miscompares++; $display("FAIL clr_pre got lvl=%0d exp=2", fifo_level);
        end
        q = 8'h23; ovf = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; ovf = 1'b0;
        vectors++;
        if ({rd_valid, fifo_full, fifo_level, event_count, drop_count, ovf_seen, rd_data} !== 38'd0) begin
            miscompares++;
            $display("FAIL clr_state got valid=%b lvl=%0d ev=%0d drop=%0d seen=%b data=%h exp all 0",
                     rd_valid, fifo_level, event_count, drop_count, ovf_seen, rd_data);
        end
        tick();
        q = 8'h30; ovf = 1'b1; t = cyc;
        tick();
        ovf = 1'b0;
        vectors++;
        if (rd_data !== {8'h30, t} || event_count !== 8'd1 || ovf_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_after got data=%h ev=%0d seen=%b exp %h 1 1",
                     rd_data, event_count, ovf_seen, {8'h30, t});
        end
        rd_ready = 1'b1;
        tick();
    endtask

    task automatic test_saturation;
        int         exp_ev;
        logic [7:0] t;
        logic [7:0] qv;
        exp_ev = 1;
        rd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            qv = 8'(i);
            q = qv; ovf = 1'b1; t = cyc;
            tick();
            ovf = 1'b0;
            exp_ev = (exp_ev < 255) ? exp_ev + 1 : 255;
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== {qv, t} || event_count !== 8'(exp_ev)) begin
                miscompares++;
                $display("FAIL sat_%0d got valid=%b data=%h ev=%0d exp 1 %h %0d",
                         i, rd_valid, rd_data, event_count, {qv, t}, exp_ev);
            end
            tick();
        end
        vectors++;
        if (event_count !== 8'hFF || drop_count !== 8'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_final got ev=%h drop=%0d valid=%b exp ff 0 0",
                     event_count, drop_count, rd_valid);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 2; i++) begin
            q = 8'h41 + 8'(i); ovf = 1'b1;
            tick();
            ovf = 1'b0;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rd_valid, fifo_full, fifo_level, event_count, drop_count, ovf_seen, rd_data} !== 38'd0) begin
            miscompares++;
            $display("FAIL async_reset got valid=%b lvl=%0d ev=%0d seen=%b data=%h exp all 0",
                     rd_valid, fifo_level, event_count, ovf_seen, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 8'd0;
        q = 8'h55; ovf = 1'b1;
        tick();
        ovf = 1'b0;
        vectors++;
        if (rd_data !== 16'h5500 || event_count !== 8'd1 || fifo_level !== 3'd1) begin
            miscompares++;
            $display("FAIL first_clk_event got data=%h ev=%0d lvl=%0d exp 5500 1 1",
                     rd_data, event_count, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_capture();
        test_fill_drop();
        test_full_push_pop();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
